uart_tx_serializer_parity: RTL



---
 rtl/uart_tx_serializer_parity_if.sv | 32 +++
 rtl/uart_tx_serializer_parity.sv | 56 +++++
 2 files changed

// File: rtl/uart_tx_serializer_parity_if.sv
// Purpose: groups the serializer's handshake and data signals between the UART TX FSM side and the serializer.
// Latency: none; this is a wiring bundle only.
// Backpressure: none; busy and serializer_enable from the FSM gate every capture and shift.
//
// Ports:
//   p_data, data_valid, parity_type      upstream byte, its strobe and its parity mode
//   busy, serializer_enable              frame-in-progress and DATA-state strobes from the FSM
//   ser_data, ser_done, par_bit          serial bit, last-bit flag and parity bit from the serializer
interface uart_tx_serializer_parity_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  busy;
    logic                  serializer_enable;
    logic                  parity_type;
    logic                  ser_data;
    logic                  ser_done;
    logic                  par_bit;

    // master: the FSM / upstream side that drives the serializer
    modport master (
        output p_data, data_valid, busy, serializer_enable, parity_type,
        input  ser_data, ser_done, par_bit
    );

    // slave: the serializer itself
    modport slave (
        input  p_data, data_valid, busy, serializer_enable, parity_type,
        output ser_data, ser_done, par_bit
    );
endinterface

// File: rtl/uart_tx_serializer_parity.sv
// Purpose: captures a parallel byte with its parity bit and shifts it out LSB-first for the UART TX FSM.
// Latency: 1 cycle from the capture edge to bit 0 on ser_data; the data phase is DATA_WIDTH enabled cycles.
// Backpressure: a capture is refused while busy or serializer_enable is high; a shift happens only while enabled.
//
// Ports:
//   clk   single clock for all registers
//   rst   asynchronous, active-high reset
//   bus   slave side of uart_tx_serializer_parity_if (p_data, data_valid, busy,
//         serializer_enable, parity_type in; ser_data, ser_done, par_bit out)
module uart_tx_serializer_parity #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    uart_tx_serializer_parity_if.slave   bus
);

    localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shift_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  par_q;
    logic                  capture;
    logic                  last_bit;

    // Enable wins over capture, so a byte offered during a shift is dropped.
    assign capture  = bus.data_valid && !bus.busy && !bus.serializer_enable;
    assign last_bit = (cnt_q == LAST_BIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
        end else if (bus.serializer_enable) begin
            shift_q <= shift_q >> 1;
            // Wrap to 0 on the last bit so the next frame starts clean.
            cnt_q   <= last_bit ? '0 : cnt_q + 1'b1;
        end else if (capture) begin
            shift_q <= bus.p_data;
            cnt_q   <= '0;
            // Even parity is the XOR of the byte; odd parity is its inverse.
            par_q   <= (^bus.p_data) ^ bus.parity_type;
        end else begin
            // Any idle cycle breaks the run, so ser_done always needs
            // DATA_WIDTH back-to-back enabled cycles. The shift register holds.
            cnt_q   <= '0;
        end
    end

    assign bus.ser_data = shift_q[0];
    assign bus.ser_done = bus.serializer_enable && last_bit;
    assign bus.par_bit  = par_q;

endmodule
